freq_meter: RTL and testbench

//   Measures the frequency of an asynchronous square-wave input against the system clock.

---
 rtl/freq_meter_pkg.sv | 43 ++++
 rtl/freq_meter_sync.sv | 42 ++++
 rtl/freq_meter.sv | 187 ++++++++++++++++++
 tb/tb_freq_meter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg
//   Shared definitions for the frequency meter:
//   - FSM state encoding (IDLE / ARM / MEASURE)
//   - gate window length derived from clock rate and gate rate
//   - saturating add helpers, written for up to 64-bit operands so that any
//     counter width up to 64 can use them through a cast
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } fm_state_e;

    // Number of clk cycles in one gate window.
    function automatic int unsigned calc_gate_cycles(input int unsigned freq_in,
                                                     input int unsigned gate_hz);
        return freq_in / gate_hz;
    endfunction

    // a + inc, clamped at max_v.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic        inc,
                                            input logic [63:0] max_v);
        logic [63:0] res;
        if (!inc) begin
            res = a;
        end else if (a >= max_v) begin
            res = max_v;
        end else begin
            res = a + 64'd1;
        end
        return res;
    endfunction

    // 1 when a + inc would exceed max_v.
    function automatic logic sat_add_ovf(input logic [63:0] a,
                                         input logic        inc,
                                         input logic [63:0] max_v);
        return inc & (a >= max_v);
    endfunction

endpackage

// File: rtl/freq_meter_sync.sv
// sync_edge
//   Synchronizer plus rising-edge detector for one asynchronous input.
//   din passes through SYNC_STAGES flops; a history flop behind the last stage
//   gives a one-cycle rise pulse.
// Ports
//   clk        system clock
//   rst        synchronous, active-low reset (clears chain and history)
//   din        asynchronous input
//   dout_sync  synchronized level
//   rise       one-cycle pulse on a synchronized 0->1 transition
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout_sync,
    output logic rise
);

    if (SYNC_STAGES < 2) begin : g_stage_chk
        $error("sync_edge: SYNC_STAGES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Synchronizer chain and history flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign dout_sync = sync_q[SYNC_STAGES-1];
    assign rise      = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter
//   Counts rising edges of an asynchronous input over back-to-back gate windows
//   of GATE_CYCLES clk cycles and reports the count at the end of each window.
// Ports
//   clk         system clock
//   rst         synchronous, active-low reset
//   sig_in      asynchronous signal under measurement
//   enable      1 = measure continuously, 0 = stop and idle
//   freq_count  edges counted in the last completed window
//   freq_valid  one-cycle pulse when freq_count updates
//   overflow    last completed window saturated at 2^CNT_W-1
//   busy        1 while arming or measuring
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned FREQ_IN     = 32'd100000000,
    parameter int unsigned GATE_HZ     = 32'd1,
    parameter int          CNT_W       = 32,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned GATE_CYCLES = calc_gate_cycles(FREQ_IN, GATE_HZ);
    localparam int          GATE_W      = $clog2(GATE_CYCLES);
    localparam int          ARM_W       = $clog2(SYNC_STAGES + 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 32'd1);
    localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    if (GATE_CYCLES < 32'd2) begin : g_gate_chk
        $error("freq_meter: GATE_CYCLES must be >= 2");
    end
    if ((CNT_W < 1) || (CNT_W > 64)) begin : g_cnt_chk
        $error("freq_meter: CNT_W must be in 1..64");
    end

    fm_state_e         state_q, state_d;
    logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic              sat_q, sat_d;
    logic [CNT_W-1:0]  freq_count_q, freq_count_d;
    logic              overflow_q, overflow_d;
    logic              valid_q, valid_d;
    logic              busy_q;

    logic              edge_now_s;
    logic              sync_lvl_s;
    logic [CNT_W-1:0]  add_val_s;
    logic              add_ovf_s;
    logic              window_end_s;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .din       (sig_in),
        .dout_sync (sync_lvl_s),
        .rise      (edge_now_s)
    );

    // The synchronized level itself is not needed here, only its rise pulse.
    logic unused_s;
    assign unused_s = sync_lvl_s;

    // Edge count including an edge on the current cycle, clamped at CNT_MAX.
    assign add_val_s    = CNT_W'(sat_add(64'(edge_cnt_q), edge_now_s, 64'(CNT_MAX)));
    assign add_ovf_s    = sat_add_ovf(64'(edge_cnt_q), edge_now_s, 64'(CNT_MAX));
    assign window_end_s = (state_q == MEASURE) && (gate_cnt_q == GATE_LAST);

    // Next-state logic: arming, gate window sequencing and result capture.
    always_comb begin
        state_d      = state_q;
        arm_cnt_d    = arm_cnt_q;
        gate_cnt_d   = gate_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        sat_d        = sat_q;
        freq_count_d = freq_count_q;
        overflow_d   = overflow_q;
        valid_d      = 1'b0;

        case (state_q)
            IDLE: begin
                arm_cnt_d  = '0;
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                if (enable) begin
                    state_d = ARM;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM: begin
                // Hold counters at zero while stale synchronizer contents drain.
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                if (!enable) begin
                    state_d   = IDLE;
                    arm_cnt_d = '0;
                end else if (arm_cnt_q == ARM_LAST) begin
                    state_d   = MEASURE;
                    arm_cnt_d = '0;
                end else begin
                    state_d   = ARM;
                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
                end
            end
            MEASURE: begin
                if (window_end_s) begin
                    // The window completes even if enable drops on this cycle.
                    freq_count_d = add_val_s;
                    overflow_d   = sat_q | add_ovf_s;
                    valid_d      = 1'b1;
                    gate_cnt_d   = '0;
                    edge_cnt_d   = '0;
                    sat_d        = 1'b0;
                    if (enable) begin
                        state_d = MEASURE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!enable) begin
                    // Partial window is dropped; results hold.
                    state_d    = IDLE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end else begin
                    state_d    = MEASURE;
                    gate_cnt_d = gate_cnt_q + GATE_W'(1);
                    edge_cnt_d = add_val_s;
                    sat_d      = sat_q | add_ovf_s;
                end
            end
            default: begin
                state_d    = IDLE;
                arm_cnt_d  = '0;
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
            end
        endcase
    end

    // State, counter and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            arm_cnt_q    <= '0;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            sat_q        <= 1'b0;
            freq_count_q <= '0;
            overflow_q   <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            arm_cnt_q    <= arm_cnt_d;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            sat_q        <= sat_d;
            freq_count_q <= freq_count_d;
            overflow_q   <= overflow_d;
            valid_q      <= valid_d;
            // Registered from next state so busy tracks state_q exactly.
            busy_q       <= (state_d != IDLE);
        end
    end

    assign freq_count = freq_count_q;
    assign freq_valid = valid_q;
    assign overflow   = overflow_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
module tb_freq_meter;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       en4;
    logic       sig_in;
    logic [7:0] cnt8;
    logic       v8, ov8, busy8;
    logic [3:0] cnt4;
    logic       v4, ov4, busy4;

    // stimulus source: mode 1 = periodic generator, mode 0 = static level
    logic mode;
    logic level;
    logic sig_gen;
    int   per;
    int   hi;
    int   ph;

    int checks;
    int errors;

    freq_meter #(.FREQ_IN(32'd1000), .GATE_HZ(32'd10), .CNT_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .enable(enable),
        .freq_count(cnt8), .freq_valid(v8), .overflow(ov8), .busy(busy8));

    freq_meter #(.FREQ_IN(32'd1000), .GATE_HZ(32'd10), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst(rst), .sig_in(sig_in), .enable(en4),
        .freq_count(cnt4), .freq_valid(v4), .overflow(ov4), .busy(busy4));

    assign sig_in = mode ? sig_gen : level;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        ph = 0;
        sig_gen = 1'b0;
        forever begin
            @(negedge clk);
            if (ph >= per - 1) ph = 0;
            else ph = ph + 1;
            sig_gen = (ph < hi);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Waits (posedge + #1 sampling) until the selected freq_valid is high.
    task automatic wait_v(input bit sel4, input string tag, output int cyc);
        bit seen;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            seen = sel4 ? v4 : v8;
        end
        chk({tag, "_timeout"}, {31'd0, seen}, 32'd1);
    endtask

    int c, c1, c2, c3;
    bit ok, seen_v;

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0; enable = 1'b0; en4 = 1'b0;
        mode = 1'b0; level = 1'b0; per = 10; hi = 5;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", {24'd0, cnt8}, 32'd0);
        chk("rst_valid", {31'd0, v8}, 32'd0);
        chk("rst_ovf",   {31'd0, ov8}, 32'd0);
        chk("rst_busy",  {31'd0, busy8}, 32'd0);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_busy", {31'd0, busy8}, 32'd0);

        // 1: period 10 -> 10 per window, windows 100 clk apart
        mode = 1'b1; per = 10; hi = 5;
        enable = 1'b1;
        wait_v(1'b0, "t1a", c);
        chk("t1_count", {24'd0, cnt8}, 32'd10);
        chk("t1_ovf",   {31'd0, ov8}, 32'd0);
        chk("t1_busy",  {31'd0, busy8}, 32'd1);
        wait_v(1'b0, "t1b", c);
        chk("t1_interval", c, 32'd100);
        chk("t1_count2", {24'd0, cnt8}, 32'd10);

        // 2: period 3 -> 33/34, three windows sum to 100
        per = 3; hi = 1;
        wait_v(1'b0, "t2d", c);
        wait_v(1'b0, "t2a", c); c1 = int'(cnt8);
        wait_v(1'b0, "t2b", c); c2 = int'(cnt8);
        wait_v(1'b0, "t2c", c); c3 = int'(cnt8);
        ok = ((c1 == 33) || (c1 == 34)) && ((c2 == 33) || (c2 == 34)) && ((c3 == 33) || (c3 == 34));
        chk("t2_range", {31'd0, ok}, 32'd1);
        chk("t2_sum", c1 + c2 + c3, 32'd100);

        // 3: 4-bit counter saturates, then recovers
        per = 4; hi = 2;
        en4 = 1'b1;
        wait_v(1'b1, "t3d", c);
        wait_v(1'b1, "t3a", c);
        chk("t3_sat_count", {28'd0, cnt4}, 32'd15);
        chk("t3_sat_ovf",   {31'd0, ov4}, 32'd1);
        per = 20; hi = 10;
        wait_v(1'b1, "t3e", c);
        wait_v(1'b1, "t3b", c);
        chk("t3_count", {28'd0, cnt4}, 32'd5);
        chk("t3_ovf",   {31'd0, ov4}, 32'd0);
        en4 = 1'b0;

        // 4: static levels, then single pulses at window boundaries
        mode = 1'b0; level = 1'b0;
        wait_v(1'b0, "t4d", c);
        wait_v(1'b0, "t4a", c);
        chk("t4_low", {24'd0, cnt8}, 32'd0);
        level = 1'b1;
        wait_v(1'b0, "t4e", c);
        wait_v(1'b0, "t4b", c);
        chk("t4_high", {24'd0, cnt8}, 32'd0);
        level = 1'b0;
        wait_v(1'b0, "t4f", c);
        wait_v(1'b0, "t4c", c);
        // now in window cycle 0; edge_now lands 2 cycles after the pin rises
        repeat (97) @(posedge clk);
        #1 level = 1'b1;
        repeat (2) @(posedge clk);
        #1 level = 1'b0;
        wait_v(1'b0, "t4g", c);
        chk("t4_pulse99", {24'd0, cnt8}, 32'd1);
        repeat (98) @(posedge clk);
        #1 level = 1'b1;
        wait_v(1'b0, "t4h", c);
        chk("t4_pulse0_old", {24'd0, cnt8}, 32'd0);
        level = 1'b0;
        wait_v(1'b0, "t4i", c);
        chk("t4_pulse0_new", {24'd0, cnt8}, 32'd1);

        // 5: enable drop mid-window, then re-enable
        mode = 1'b1; per = 10; hi = 5;
        wait_v(1'b0, "t5d", c);
        wait_v(1'b0, "t5a", c);
        chk("t5_pre", {24'd0, cnt8}, 32'd10);
        repeat (50) @(posedge clk);
        #1 enable = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_busy", {31'd0, busy8}, 32'd0);
        seen_v = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1;
            if (v8) seen_v = 1'b1;
        end
        chk("t5_no_valid", {31'd0, seen_v}, 32'd0);
        chk("t5_hold", {24'd0, cnt8}, 32'd10);
        enable = 1'b1;
        @(posedge clk);
        #1;
        wait_v(1'b0, "t5b", c);
        chk("t5_restart_lat", c, 32'd103);
        chk("t5_restart_count", {24'd0, cnt8}, 32'd10);

        // 6: reset mid-window
        repeat (70) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_count", {24'd0, cnt8}, 32'd0);
        chk("t6_valid", {31'd0, v8}, 32'd0);
        chk("t6_ovf",   {31'd0, ov8}, 32'd0);
        chk("t6_busy",  {31'd0, busy8}, 32'd0);
        chk("t6_count4", {28'd0, cnt4}, 32'd0);
        seen_v = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (v8) seen_v = 1'b1;
        end
        chk("t6_no_valid", {31'd0, seen_v}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        wait_v(1'b0, "t6b", c);
        chk("t6_restart_lat", c, 32'd103);
        chk("t6_restart_count", {24'd0, cnt8}, 32'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
